fpr_writeback: RTL and testbench

FPR_WRITEBACK -- requirements
Module: fpr_writeback

---
 rtl/fpr_pkg.sv | 22 ++
 rtl/fpr_wb_fifo.sv | 59 +++++
 rtl/fpr_writeback.sv | 143 ++++++++++++++
 tb/tb_fpr_writeback.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpr_pkg.sv
// rtl/fpr_pkg.sv - shared sizes, FSM states and request record for the FPR writeback block
package fpr_pkg;

  localparam int FPR_ADDR_W = 5;
  localparam int FPR_DATA_W = 32;
  localparam int FIFO_DEPTH = 2;
  localparam int NUM_FPR    = 1 << FPR_ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    WR_HI,
    WR_LO
  } wb_state_e;

  typedef struct packed {
    logic [FPR_ADDR_W-1:0] dest;
    logic                  dbl;
    logic [FPR_DATA_W-1:0] hi;
    logic [FPR_DATA_W-1:0] lo;
  } fpr_req_t;

endpackage

// File: rtl/fpr_wb_fifo.sv
// rtl/fpr_wb_fifo.sv - small in-order request FIFO; pushes into a full FIFO are ignored
module fpr_wb_fifo
  import fpr_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     push_i,
  input  fpr_req_t push_data_i,
  input  logic     pop_i,
  output logic     full_o,
  output logic     empty_o,
  output fpr_req_t head_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fpr_req_t         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/fpr_writeback.sv
// rtl/fpr_writeback.sv - queues single/pair FPR writebacks and sequences them onto registered FPR write ports
module fpr_writeback
  import fpr_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic [FPR_ADDR_W-1:0] reqDest,
  input  logic                  reqDouble,
  input  logic [FPR_DATA_W-1:0] reqDataHi,
  input  logic [FPR_DATA_W-1:0] reqDataLo,
  output logic                  fprRegWr,
  output logic [FPR_ADDR_W-1:0] fprRd,
  output logic [FPR_ADDR_W-1:0] fprRt,
  output logic                  fprRdst,
  output logic [FPR_DATA_W-1:0] fprBusW,
  output logic [NUM_FPR-1:0]    pendingMask,
  output logic                  errOddPair
);

  wb_state_e             state_q, state_d;
  logic                  wr_q, wr_d;
  logic [FPR_ADDR_W-1:0] rd_q, rd_d;
  logic [FPR_DATA_W-1:0] busw_q, busw_d;
  logic                  cur_dbl_q, cur_dbl_d;
  logic [NUM_FPR-1:0]    pend_q, pend_d;
  logic                  err_q, err_d;

  logic                  push, pop, fifo_full, fifo_empty, load_hi;
  fpr_req_t              in_req, head;
  logic [FPR_ADDR_W-1:0] in_pair_dest, head_pair_dest;
  logic [NUM_FPR-1:0]    set_mask, clr_mask;

  assign reqReady = !fifo_full && !reset;
  assign push     = reqValid && reqReady;

  always_comb begin
    in_req.dest = reqDest;
    if (reqDouble) begin
      in_req.dest[0] = 1'b0;
    end
    in_req.dbl = reqDouble;
    in_req.hi  = reqDataHi;
    in_req.lo  = reqDataLo;
  end

  assign in_pair_dest   = in_req.dest + FPR_ADDR_W'(1);
  assign head_pair_dest = head.dest + FPR_ADDR_W'(1);

  fpr_wb_fifo u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (in_req),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  // A single is popped as it is loaded; a pair stays at the head until its low half loads,
  // which keeps the two FIFO slots free enough for one write per cycle.
  always_comb begin
    state_d   = state_q;
    wr_d      = 1'b0;
    rd_d      = rd_q;
    busw_d    = busw_q;
    cur_dbl_d = cur_dbl_q;
    pop       = 1'b0;
    load_hi   = 1'b0;
    case (state_q)
      IDLE:  load_hi = !fifo_empty;
      WR_HI: begin
        if (cur_dbl_q) begin
          state_d   = WR_LO;
          wr_d      = 1'b1;
          rd_d      = head_pair_dest;
          busw_d    = head.lo;
          cur_dbl_d = 1'b0;
          pop       = 1'b1;
        end else begin
          load_hi = !fifo_empty;
          if (fifo_empty) state_d = IDLE;
        end
      end
      WR_LO: begin
        load_hi = !fifo_empty;
        if (fifo_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load_hi) begin
      state_d   = WR_HI;
      wr_d      = 1'b1;
      rd_d      = head.dest;
      busw_d    = head.hi;
      cur_dbl_d = head.dbl;
      pop       = !head.dbl;
    end
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (push) begin
      set_mask[in_req.dest] = 1'b1;
      if (in_req.dbl) set_mask[in_pair_dest] = 1'b1;
    end
    if (wr_q) clr_mask[rd_q] = 1'b1;
    pend_d = (pend_q & ~clr_mask) | set_mask;
    err_d  = push && reqDouble && reqDest[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_q      <= 1'b0;
      rd_q      <= '0;
      busw_q    <= '0;
      cur_dbl_q <= 1'b0;
      pend_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      busw_q    <= busw_d;
      cur_dbl_q <= cur_dbl_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
    end
  end

  assign fprRegWr    = wr_q;
  assign fprRd       = rd_q;
  assign fprRt       = rd_q;
  assign fprRdst     = 1'b1;
  assign fprBusW     = busw_q;
  assign pendingMask = pend_q;
  assign errOddPair  = err_q;

endmodule

// File: tb/tb_fpr_writeback.sv
// tb/tb_fpr_writeback.sv - directed self-checking bench for fpr_writeback
module tb_fpr_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic [4:0]  reqDest;
  logic        reqDouble;
  logic [31:0] reqDataHi;
  logic [31:0] reqDataLo;
  logic        fprRegWr;
  logic [4:0]  fprRd;
  logic [4:0]  fprRt;
  logic        fprRdst;
  logic [31:0] fprBusW;
  logic [31:0] pendingMask;
  logic        errOddPair;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [31:0] fpr_model [32];
  int          log_rd [$];
  logic [31:0] log_data [$];
  int          log_cyc [$];

  fpr_writeback dut (
    .clk         (clk),
    .reset       (reset),
    .reqValid    (reqValid),
    .reqReady    (reqReady),
    .reqDest     (reqDest),
    .reqDouble   (reqDouble),
    .reqDataHi   (reqDataHi),
    .reqDataLo   (reqDataLo),
    .fprRegWr    (fprRegWr),
    .fprRd       (fprRd),
    .fprRt       (fprRt),
    .fprRdst     (fprRdst),
    .fprBusW     (fprBusW),
    .pendingMask (pendingMask),
    .errOddPair  (errOddPair)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: writes on the falling edge, as the real FPR file does.
  always @(negedge clk) begin
    if (fprRegWr === 1'b1) begin
      fpr_model[fprRd] = fprBusW;
      log_rd.push_back(int'(fprRd));
      log_data.push_back(fprBusW);
      log_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [4:0] d, input logic dbl,
                       input logic [31:0] hi, input logic [31:0] lo);
    reqValid  = v;
    reqDest   = d;
    reqDouble = dbl;
    reqDataHi = hi;
    reqDataLo = lo;
  endtask

  task automatic clear_log();
    log_rd.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    n_checks++; if (fprRegWr !== 1'b0) $display("FAIL rst_wr got=%b exp=0", fprRegWr); else n_pass++;
    n_checks++; if (fprRd !== 5'd0) $display("FAIL rst_rd got=%0d exp=0", fprRd); else n_pass++;
    n_checks++; if (fprRt !== 5'd0) $display("FAIL rst_rt got=%0d exp=0", fprRt); else n_pass++;
    n_checks++; if (fprRdst !== 1'b1) $display("FAIL rst_rdst got=%b exp=1", fprRdst); else n_pass++;
    n_checks++; if (fprBusW !== 32'h0) $display("FAIL rst_busw got=%h exp=0", fprBusW); else n_pass++;
    n_checks++; if (pendingMask !== 32'h0) $display("FAIL rst_pending got=%h exp=0", pendingMask); else n_pass++;
    n_checks++; if (errOddPair !== 1'b0) $display("FAIL rst_err got=%b exp=0", errOddPair); else n_pass++;
    n_checks++; if (reqReady !== 1'b0) $display("FAIL rst_ready got=%b exp=0", reqReady); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if (reqReady !== 1'b1) $display("FAIL post_rst_ready got=%b exp=1", reqReady); else n_pass++;
    tick();
    n_checks++; if (fprRegWr !== 1'b0) $display("FAIL post_rst_wr got=%b exp=0", fprRegWr); else n_pass++;
  endtask

  task automatic test_single();
    clear_log();
    drive(1'b1, 5'd3, 1'b0, 32'h3F800000, 32'h0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    n_checks++; if (pendingMask !== 32'h8) $display("FAIL single_pend_set got=%h exp=8", pendingMask); else n_pass++;
    n_checks++; if (fprRegWr !== 1'b0) $display("FAIL single_wr_early got=%b exp=0", fprRegWr); else n_pass++;
    tick();
    n_checks++; if (fprRegWr !== 1'b1) $display("FAIL single_wr got=%b exp=1", fprRegWr); else n_pass++;
    n_checks++; if (fprRd !== 5'd3) $display("FAIL single_rd got=%0d exp=3", fprRd); else n_pass++;
    n_checks++; if (fprRt !== 5'd3) $display("FAIL single_rt got=%0d exp=3", fprRt); else n_pass++;
    n_checks++; if (fprBusW !== 32'h3F800000) $display("FAIL single_busw got=%h exp=3f800000", fprBusW); else n_pass++;
    n_checks++; if (pendingMask !== 32'h8) $display("FAIL single_pend_hold got=%h exp=8", pendingMask); else n_pass++;
    tick();
    n_checks++; if (fprRegWr !== 1'b0) $display("FAIL single_idle got=%b exp=0", fprRegWr); else n_pass++;
    n_checks++; if (pendingMask !== 32'h0) $display("FAIL single_pend_clr got=%h exp=0", pendingMask); else n_pass++;
    n_checks++; if (fpr_model[3] !== 32'h3F800000) $display("FAIL single_fpr3 got=%h exp=3f800000", fpr_model[3]); else n_pass++;
    n_checks++; if (log_rd.size() != 1) $display("FAIL single_nwrites got=%0d exp=1", log_rd.size()); else n_pass++;
  endtask

  task automatic test_double();
    clear_log();
    drive(1'b1, 5'd4, 1'b1, 32'h40090000, 32'h00000001);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    n_checks++; if (pendingMask !== 32'h30) $display("FAIL dbl_pend_set got=%h exp=30", pendingMask); else n_pass++;
    n_checks++; if (errOddPair !== 1'b0) $display("FAIL dbl_err got=%b exp=0", errOddPair); else n_pass++;
    tick();
    n_checks++; if (fprRegWr !== 1'b1 || fprRd !== 5'd4) $display("FAIL dbl_hi_rd got wr=%b rd=%0d exp wr=1 rd=4", fprRegWr, fprRd); else n_pass++;
    n_checks++; if (fprBusW !== 32'h40090000) $display("FAIL dbl_hi_busw got=%h exp=40090000", fprBusW); else n_pass++;
    n_checks++; if (pendingMask !== 32'h30) $display("FAIL dbl_pend_hi got=%h exp=30", pendingMask); else n_pass++;
    tick();
    n_checks++; if (fprRegWr !== 1'b1 || fprRd !== 5'd5) $display("FAIL dbl_lo_rd got wr=%b rd=%0d exp wr=1 rd=5", fprRegWr, fprRd); else n_pass++;
    n_checks++; if (fprBusW !== 32'h00000001) $display("FAIL dbl_lo_busw got=%h exp=00000001", fprBusW); else n_pass++;
    n_checks++; if (pendingMask !== 32'h20) $display("FAIL dbl_pend_lo got=%h exp=20", pendingMask); else n_pass++;
    tick();
    n_checks++; if (fprRegWr !== 1'b0) $display("FAIL dbl_idle got=%b exp=0", fprRegWr); else n_pass++;
    n_checks++; if (pendingMask !== 32'h0) $display("FAIL dbl_pend_clr got=%h exp=0", pendingMask); else n_pass++;
    n_checks++; if (fpr_model[4] !== 32'h40090000) $display("FAIL dbl_fpr4 got=%h exp=40090000", fpr_model[4]); else n_pass++;
    n_checks++; if (fpr_model[5] !== 32'h00000001) $display("FAIL dbl_fpr5 got=%h exp=00000001", fpr_model[5]); else n_pass++;
  endtask

  task automatic test_backpressure();
    int          dests [3];
    int          stalls [3];
    int          exp_rd [6];
    logic [31:0] exp_data [6];
    logic        acc;
    logic        accepted;
    logic        rdy_after2;
    dests = '{8, 12, 16};
    rdy_after2 = 1'b1;
    clear_log();
    for (int i = 0; i < 3; i++) begin
      stalls[i] = 0;
      accepted  = 1'b0;
      exp_rd[2*i]     = dests[i];
      exp_rd[2*i+1]   = dests[i] + 1;
      exp_data[2*i]   = 32'hB0000000 + 32'(dests[i]);
      exp_data[2*i+1] = 32'hC0000000 + 32'(dests[i]);
      drive(1'b1, 5'(dests[i]), 1'b1, exp_data[2*i], exp_data[2*i+1]);
      for (int k = 0; k < 10 && !accepted; k++) begin
        acc = reqReady;
        tick();
        if (acc) accepted = 1'b1;
        else stalls[i]++;
      end
      n_checks++; if (!accepted) $display("FAIL bp_accept_timeout req=%0d got=not_accepted exp=accepted", i); else n_pass++;
      if (i == 1) rdy_after2 = reqReady;
    end
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    repeat (8) tick();
    n_checks++; if (rdy_after2 !== 1'b0) $display("FAIL bp_ready_after2 got=%b exp=0", rdy_after2); else n_pass++;
    n_checks++; if (stalls[1] != 0) $display("FAIL bp_stall2 got=%0d exp=0", stalls[1]); else n_pass++;
    n_checks++; if (stalls[2] != 1) $display("FAIL bp_stall3 got=%0d exp=1", stalls[2]); else n_pass++;
    n_checks++; if (log_rd.size() != 6) $display("FAIL bp_nwrites got=%0d exp=6", log_rd.size()); else n_pass++;
    for (int j = 0; j < 6; j++) begin
      n_checks++;
      if (j >= log_rd.size() || log_rd[j] != exp_rd[j] || log_data[j] !== exp_data[j])
        $display("FAIL bp_order idx=%0d got rd=%0d data=%h exp rd=%0d data=%h", j,
                 (j < log_rd.size()) ? log_rd[j] : -1, (j < log_rd.size()) ? log_data[j] : 32'hx,
                 exp_rd[j], exp_data[j]);
      else n_pass++;
    end
    n_checks++;
    if (log_cyc.size() != 6 || log_cyc[5] - log_cyc[0] != 5)
      $display("FAIL bp_span got=%0d exp=5", (log_cyc.size() == 6) ? log_cyc[5] - log_cyc[0] : -1);
    else n_pass++;
    n_checks++; if (pendingMask !== 32'h0) $display("FAIL bp_pend_clr got=%h exp=0", pendingMask); else n_pass++;
  endtask

  task automatic test_odd_pair();
    clear_log();
    drive(1'b1, 5'd7, 1'b1, 32'h11110007, 32'h22220007);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    n_checks++; if (errOddPair !== 1'b1) $display("FAIL odd_err_pulse got=%b exp=1", errOddPair); else n_pass++;
    n_checks++; if (pendingMask !== 32'hC0) $display("FAIL odd_pend got=%h exp=c0", pendingMask); else n_pass++;
    tick();
    n_checks++; if (errOddPair !== 1'b0) $display("FAIL odd_err_once got=%b exp=0", errOddPair); else n_pass++;
    n_checks++; if (fprRegWr !== 1'b1 || fprRd !== 5'd6) $display("FAIL odd_hi got wr=%b rd=%0d exp wr=1 rd=6", fprRegWr, fprRd); else n_pass++;
    tick();
    n_checks++; if (fprRegWr !== 1'b1 || fprRd !== 5'd7) $display("FAIL odd_lo got wr=%b rd=%0d exp wr=1 rd=7", fprRegWr, fprRd); else n_pass++;
    n_checks++; if (errOddPair !== 1'b0) $display("FAIL odd_err_late got=%b exp=0", errOddPair); else n_pass++;
    tick();
    n_checks++; if (fpr_model[6] !== 32'h11110007) $display("FAIL odd_fpr6 got=%h exp=11110007", fpr_model[6]); else n_pass++;
    n_checks++; if (fpr_model[7] !== 32'h22220007) $display("FAIL odd_fpr7 got=%h exp=22220007", fpr_model[7]); else n_pass++;
  endtask

  task automatic test_reset_mid_pair();
    logic [31:0] before10, before11;
    before10 = fpr_model[10];
    before11 = fpr_model[11];
    clear_log();
    drive(1'b1, 5'd10, 1'b1, 32'hAAAA000A, 32'hBBBB000B);
    tick();
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    tick();
    n_checks++; if (fprRegWr !== 1'b1 || fprRd !== 5'd10) $display("FAIL rmp_in_hi got wr=%b rd=%0d exp wr=1 rd=10", fprRegWr, fprRd); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (fprRegWr !== 1'b0) $display("FAIL rmp_wr got=%b exp=0", fprRegWr); else n_pass++;
    n_checks++; if (pendingMask !== 32'h0) $display("FAIL rmp_pend got=%h exp=0", pendingMask); else n_pass++;
    n_checks++; if (fprRd !== 5'd0 || fprBusW !== 32'h0) $display("FAIL rmp_outs got rd=%0d busw=%h exp rd=0 busw=0", fprRd, fprBusW); else n_pass++;
    n_checks++; if (reqReady !== 1'b0) $display("FAIL rmp_ready got=%b exp=0", reqReady); else n_pass++;
    tick();
    tick();
    reset = 1'b0;
    repeat (4) tick();
    n_checks++; if (log_rd.size() != 0) $display("FAIL rmp_nwrites got=%0d exp=0", log_rd.size()); else n_pass++;
    n_checks++; if (fpr_model[11] !== before11) $display("FAIL rmp_fpr11 got=%h exp=%h", fpr_model[11], before11); else n_pass++;
    n_checks++; if (fpr_model[10] !== before10) $display("FAIL rmp_fpr10 got=%h exp=%h", fpr_model[10], before10); else n_pass++;
    n_checks++; if (reqReady !== 1'b1) $display("FAIL rmp_ready_after got=%b exp=1", reqReady); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int drops;
    drops = 0;
    clear_log();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'(i), 1'b0, 32'h00000100 + 32'(i), 32'h0);
      if (reqReady !== 1'b1) drops++;
      tick();
    end
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    repeat (4) tick();
    n_checks++; if (drops != 0) $display("FAIL b2b_ready_drops got=%0d exp=0", drops); else n_pass++;
    n_checks++; if (log_rd.size() != 8) $display("FAIL b2b_nwrites got=%0d exp=8", log_rd.size()); else n_pass++;
    for (int j = 0; j < 8; j++) begin
      n_checks++;
      if (j >= log_rd.size() || log_rd[j] != j || log_data[j] !== 32'h00000100 + 32'(j))
        $display("FAIL b2b_order idx=%0d got rd=%0d data=%h exp rd=%0d data=%h", j,
                 (j < log_rd.size()) ? log_rd[j] : -1, (j < log_rd.size()) ? log_data[j] : 32'hx,
                 j, 32'h00000100 + 32'(j));
      else n_pass++;
    end
    n_checks++;
    if (log_cyc.size() != 8 || log_cyc[7] - log_cyc[0] != 7)
      $display("FAIL b2b_span got=%0d exp=7", (log_cyc.size() == 8) ? log_cyc[7] - log_cyc[0] : -1);
    else n_pass++;
    n_checks++; if (pendingMask !== 32'h0) $display("FAIL b2b_pend_clr got=%h exp=0", pendingMask); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) fpr_model[i] = 32'hDEAD0000 | 32'(i);
    test_reset();
    test_single();
    test_double();
    test_backpressure();
    test_odd_pair();
    test_reset_mid_pair();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
